// File: rtl/cache_pkg.sv
// Shared cache constants, state encoding and address helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
`timescale 1ns/1ps
package cache_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int LINE_BITS      = $clog2(WORDS_PER_LINE);
  localparam int BYTE_BITS      = 2;

  // Clears the word-index and byte-offset bits, leaving the line base address.
  localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFF_FFFF << (LINE_BITS + BYTE_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } clw_state_t;

  // Byte address of word idx within the line at base; base is line aligned,
  // so the offset never carries into the line-address bits.
  function automatic logic [31:0] word_addr(input logic [31:0]          base,
                                            input logic [LINE_BITS-1:0] idx);
    return base + (32'(idx) << BYTE_BITS);
  endfunction

endpackage

// File: rtl/line_word_counter.sv
// Word index within a cache line, shared by the fill and write-back paths.
// Latency: count updates on the edge after clear/advance.
// Backpressure: advances only when the owner says so; wraps after the last word.
`timescale 1ns/1ps
module line_word_counter
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 clear,
  input  logic                 advance,
  output logic [LINE_BITS-1:0] count,
  output logic                 last
);

  assign last = (count == LINE_BITS'(WORDS_PER_LINE - 1));

  // Clear wins over advance; advancing past the last word wraps to zero.
  always_ff @(posedge clk) begin
    if (clr || clear) begin
      count <= '0;
    end else if (advance) begin
      count <= last ? '0 : count + LINE_BITS'(1);
    end
  end

endmodule

// File: rtl/cache_line_writer.sv
// Serializes one captured dirty cache line into per-word memory writes; optional
// per-word dirty mask when CLW_DIRTY_MASK_EN is defined. Latency: word 0 the cycle
// after start, done one cycle after the last word. Backpressure: each word holds until mem_ready_i.
`timescale 1ns/1ps
module cache_line_writer
  import cache_pkg::*;
(
  input  logic                                clk,
  input  logic                                clr,
  input  logic                                start,
  input  logic [31:0]                         line_addr_i,
  input  logic [WORDS_PER_LINE*WORD_SIZE-1:0] line_i,
`ifdef CLW_DIRTY_MASK_EN
  input  logic [WORDS_PER_LINE-1:0]           dirty_i,
`endif
  input  logic                                mem_ready_i,
  output logic                                mem_we_o,
  output logic [31:0]                         mem_addr_o,
  output logic [31:0]                         mem_data_o,
  output logic                                busy,
  output logic                                done
);

  clw_state_t                state;
  logic [WORD_SIZE-1:0]      line_buf [WORDS_PER_LINE];
  logic [31:0]               base;
  logic [WORDS_PER_LINE-1:0] mask;
  logic [WORDS_PER_LINE-1:0] start_mask;
  logic [LINE_BITS-1:0]      count;
  logic [LINE_BITS-1:0]      next_idx;
  logic                      last;
  logic                      clear;
  logic                      skip;
  logic                      advance;

`ifdef CLW_DIRTY_MASK_EN
  assign start_mask = dirty_i;
`else
  // Without the mask feature every word is treated as dirty.
  assign start_mask = '1;
  assign mask       = '1;
`endif

  // Clean words pass in one cycle without a handshake; dirty words wait for ready.
  assign skip     = (state == WRITE) && !mask[count];
  assign advance  = (mem_we_o && mem_ready_i) || skip;
  assign clear    = (state != WRITE);
  assign next_idx = count + LINE_BITS'(1);

  line_word_counter u_counter (
    .clk     (clk),
    .clr     (clr),
    .clear   (clear),
    .advance (advance),
    .count   (count),
    .last    (last)
  );

  // Control FSM; memory-side outputs are registered and preloaded with the next word.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
              line_buf[k] <= line_i[k*WORD_SIZE +: WORD_SIZE];
            end
            base <= line_addr_i & LINE_ADDR_MASK;
`ifdef CLW_DIRTY_MASK_EN
            mask <= dirty_i;
`endif
            busy <= 1'b1;
            if (start_mask == '0) begin
              // Nothing dirty: report completion without touching memory.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= WRITE;
              mem_we_o   <= start_mask[0];
              mem_addr_o <= line_addr_i & LINE_ADDR_MASK;
              mem_data_o <= line_i[WORD_SIZE-1:0];
            end
          end
        end
        WRITE: begin
          if (advance) begin
            if (last) begin
              state      <= DONE;
              done       <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= '0;
              mem_data_o <= '0;
            end else begin
              mem_we_o   <= mask[next_idx];
              mem_addr_o <= word_addr(base, next_idx);
              mem_data_o <= line_buf[next_idx];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_line_writer.md
# cache_line_writer

Write-back serializer for the cache: accepts one full dirty line (8 x 32-bit words) plus its address in a single cycle, then issues the words to memory one per accepted handshake at consecutive word addresses. It is the outbound counterpart of the line-fill path, sitting between the cache data array and the memory write port. It signals completion with a one-cycle `done` pulse.

## Interface
- `WORD_SIZE`, 32, bits per word
- `WORDS_PER_LINE`, 8, words per cache line (power of two)
- `LINE_BITS`, $clog2(WORDS_PER_LINE), word-index width
- `BYTE_BITS`, 2, byte-offset bits per word
- `clk` in 1 — single clock, all state on rising edge
- `clr` in 1 — reset, synchronous, active-high
- `start` in 1 — request write-back; sampled only in IDLE
- `line_addr_i` in 32 — any byte address inside the line to write back
- `line_i` in WORDS_PER_LINE*WORD_SIZE — line data, word k at bits [k*32+31:k*32]
- `dirty_i` in WORDS_PER_LINE — per-word dirty mask (present only with `CLW_DIRTY_MASK_EN`)
- `mem_ready_i` in 1 — memory accepts the current word this cycle
- `mem_we_o` out 1 — word write valid
- `mem_addr_o` out 32 — word byte address
- `mem_data_o` out 32 — word data
- `busy` out 1 — high in LOAD-free states WRITE and DONE
- `done` out 1 — one-cycle completion pulse

## Operation
- States: IDLE, WRITE, DONE. Reset state IDLE, counter 0.
- IDLE: on `start`=1, capture `line_i` into an internal 8-word buffer, capture `{line_addr_i[31:5], 5'd0}` as base, capture mask, counter <= 0, go WRITE.
- WRITE: `mem_we_o`=1, `mem_addr_o` = base + (counter << 2), `mem_data_o` = buffer[counter].
- Handshake: word transfers when `mem_we_o` && `mem_ready_i`; counter +1. Without ready, addr/data/we hold stable.
- Transfer of word WORDS_PER_LINE-1 -> DONE (counter wraps to 0).
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `start` outside IDLE ignored; captured buffer/address unaffected by input changes after capture.
- Outside WRITE: `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
- Address arithmetic is 32-bit, offset at most 28; no carry into bits above [4:0] of base.

## Timing
- Reset values: `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `busy`=0, `done`=0.
- `start` at edge N -> word 0 presented in cycle N+1.
- With `mem_ready_i` held 1: words 0..7 in cycles N+1..N+8, `done` in N+9, next `start` accepted at edge N+10 earliest.
- Each ready=0 cycle in WRITE adds exactly one cycle of latency.
- `clr` mid-transfer: next cycle IDLE, outputs at reset values; words already accepted are not retracted; `done` not pulsed.
- `clr` and `start` on the same edge: `clr` wins, start is dropped.

## Configuration
- `CLW_DIRTY_MASK_EN` defined: `dirty_i` port exists. In WRITE, a clean word (mask bit 0) drives `mem_we_o`=0 for one cycle and the counter advances without waiting for ready. If the captured mask is all zero, IDLE goes directly to DONE.
- Undefined: no `dirty_i` port; all 8 words written every time.

## Structure
- Shared package `cache_pkg`: WORD_SIZE, WORDS_PER_LINE, LINE_BITS, BYTE_BITS, line-address mask constant, state enum `clw_state_t`.
- Sub-module `line_word_counter`: LINE_BITS-bit counter with clear and advance, wrap at WORDS_PER_LINE-1 with last-word flag. The same counter also serves the fill path.

## Test plan
- Ready always 1, `line_addr_i`=0x0000_1234, word k = 0xA0+k -> writes to addr 0x1220+4k with data 0xA0+k, cycles 1..8 after start; `done` at cycle 9.
- Ready toggling 1,0,1,0 -> each word held stable while ready=0; 8 writes total, no duplicates, `done` after 16 cycles.
- `start` pulsed during WRITE with different data -> ignored; the original line is written unchanged.
- `clr` asserted after word 3 is accepted -> next cycle outputs 0, no `done`; a new `start` then writes all 8 words from word 0.
- `CLW_DIRTY_MASK_EN`, `dirty_i`=8'b1000_0101 -> writes only words 0, 2, 7; mask 8'h00 -> `done` one cycle after start, no writes.
- Base 0xFFFF_FFE0, ready=1 -> last address 0xFFFF_FFFC, no wrap past the line.
